// File: rtl/rtf65002_muldiv.sv
// Iterative radix-2 multiply/divide unit: one product or quotient bit per cycle,
// with sign stripping on entry and sign restoration in a final fix-up cycle.
module rtf65002_muldiv #(
  parameter int WID = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WID-1:0]     a,
  input  logic [WID-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [2*WID-1:0]   prod,
  output logic [WID-1:0]     res
);

  localparam int CW = $clog2(WID);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic               r_neg_q, r_neg_r, r_dbz;
  logic [WID-1:0]     r_mcand;
  logic [2*WID-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_rsvd, w_div, w_dbz;
  logic [WID-1:0]     w_a_abs, w_b_abs;
  logic [WID:0]       w_mul_sum, w_rem_sh;
  logic [WID-1:0]     w_rem_sub;
  logic               w_ge;
  logic [2*WID-1:0]   w_mul_next, w_div_next, w_prod_fix;
  logic [WID-1:0]     w_quo_s, w_rem_s, w_res_fix;

  assign w_rsvd  = op[2] & op[1];
  assign w_div   = (op[2] | op[1]) & ~w_rsvd;
  assign w_dbz   = w_div && (b == {WID{1'b0}});
  assign w_a_abs = (op[0] && a[WID-1]) ? -a : a;
  assign w_b_abs = (op[0] && b[WID-1]) ? -b : b;

  // Multiplier step: conditional add into the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WID-1:WID]} + (r_acc[0] ? {1'b0, r_mcand} : {(WID+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WID-1:1]};

  // Divider step: the shifted remainder can need one extra bit before the compare.
  assign w_rem_sh   = r_acc[2*WID-1:WID-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_mcand});
  assign w_rem_sub  = w_rem_sh[WID-1:0] - r_mcand;
  assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[WID-1:0]), r_acc[WID-2:0], w_ge};

  assign w_quo_s = r_neg_q ? -r_acc[WID-1:0] : r_acc[WID-1:0];
  assign w_rem_s = r_neg_r ? -r_acc[2*WID-1:WID] : r_acc[2*WID-1:WID];

  // Sign restoration and result selection for the FIX cycle.
  always_comb begin
    w_prod_fix = {(2*WID){1'b0}};
    w_res_fix  = {WID{1'b0}};
    case (r_op)
      3'd0, 3'd1: begin
        w_prod_fix = r_neg_q ? -r_acc : r_acc;
        w_res_fix  = w_prod_fix[WID-1:0];
      end
      3'd2, 3'd3, 3'd4, 3'd5: begin
        // Divide-by-zero results were preloaded into the accumulator at start.
        if (r_dbz) w_prod_fix = r_acc;
        else       w_prod_fix = {w_rem_s, w_quo_s};
        if (r_op[2]) w_res_fix = w_prod_fix[2*WID-1:WID];
        else         w_res_fix = w_prod_fix[WID-1:0];
      end
      default: begin
        w_prod_fix = {(2*WID){1'b0}};
        w_res_fix  = {WID{1'b0}};
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (w_rsvd || w_dbz)) w_next = S_FIX;
        else if (start)                 w_next = S_CALC;
        else                            w_next = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == {CW{1'b0}}) w_next = S_FIX;
        else                     w_next = S_CALC;
      end
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 3'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_mcand <= {WID{1'b0}};
      r_acc   <= {(2*WID){1'b0}};
      r_cnt   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      prod    <= {(2*WID){1'b0}};
      res     <= {WID{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_op    <= op;
            r_neg_q <= op[0] & (a[WID-1] ^ b[WID-1]);
            r_neg_r <= op[0] & a[WID-1];
            r_dbz   <= w_dbz;
            r_cnt   <= CW'(WID-1);
            if (w_rsvd) begin
              r_acc   <= {(2*WID){1'b0}};
              r_mcand <= {WID{1'b0}};
            end else if (w_dbz) begin
              r_acc   <= {a, {WID{1'b1}}};
              r_mcand <= {WID{1'b0}};
            end else if (!w_div) begin
              r_acc   <= {{WID{1'b0}}, w_b_abs};
              r_mcand <= w_a_abs;
            end else begin
              r_acc   <= {{WID{1'b0}}, w_a_abs};
              r_mcand <= w_b_abs;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] | r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          prod <= w_prod_fix;
          res  <= w_res_fix;
          dbz  <= r_dbz;
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_DONE: done <= 1'b0;
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rtf65002_muldiv.md
Name: rtf65002_muldiv

Overview:
- Iterative 32-bit multiply/divide unit for the rtf65002 core; produces the 64-bit `prod` value the ALU reads (TSR 2/3).
- Also returns a 32-bit result for the MUL/DIV/MOD immediate and register forms.
- Radix-2 shift-add / restoring-subtract engine: one bit per cycle, with sign correction before and after.
- Started by the execute state machine; result is held stable until the next accepted start.

Parameters:
WID, 32, operand width; prod is 2*WID. Only 32 is verified.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  3  0 MULU, 1 MULS, 2 DIVU, 3 DIVS, 4 MODU, 5 MODS, 6-7 reserved
a  in  32  multiplicand / dividend
b  in  32  multiplier / divisor
busy  out  1  high from the accepting edge until the edge that asserts done
done  out  1  single-cycle completion pulse
dbz  out  1  divide-by-zero flag; valid with done, held until next accepted start
prod  out  64  MUL: full product; DIV/MOD: {remainder, quotient}
res  out  32  MUL: prod[31:0]; DIV: quotient; MOD: remainder

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy=0, done=0, dbz=0, prod=0, res=0; all internal registers cleared. Reset mid-operation abandons the operation; no done is produced.
- States:
  - IDLE: start=1 latches op; latches |a| and |b| for signed ops, a and b unchanged for unsigned ops; records result sign.
    - DIV/MOD with b==0: go to FIX.
    - op 6/7: go to FIX.
    - Otherwise: busy=1, iteration counter=31, go to CALC.
  - CALC: one bit per cycle, exactly 32 cycles (counter 31 down to 0), then FIX.
    - MUL: if the multiplier LSB is set, add the multiplicand into the upper accumulator half; then shift the 64-bit accumulator right.
    - DIV: shift {rem, quo} left; subtract the divisor from rem if the result is non-negative; quotient bit = 1 when the subtraction is taken.
  - FIX: apply signs and register prod/res/dbz; done=1 and busy=0 take effect at this edge; next state DONE.
  - DONE: done returns to 0; go to IDLE. A start arriving in DONE is ignored.
- Latency:
  - Start accepted at edge k → done high for the cycle after edge k+33.
  - Divide-by-zero and reserved ops → done high after edge k+1.
  - Next start accepted no earlier than 2 cycles after done.
- start while busy or in DONE is ignored, with no queuing.
- Signed rules:
  - MULS: 64-bit two's-complement product; negated when the signs of a and b differ.
  - DIVS: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- Divide by zero: quotient=0xFFFFFFFF, remainder=a (unmodified, even for signed ops), dbz=1.
- Reserved op: prod=0, res=0, dbz=0.
- Output holding:
  - prod, res and dbz change only at the FIX edge and at reset.
  - busy and done are never both high.

Test Plan:
- MULS a=0xFFFFFFFD (-3), b=7 → done after 33 cycles; prod=0xFFFFFFFF_FFFFFFEB, res=0xFFFFFFEB, dbz=0.
- MULU a=b=0xFFFFFFFF → prod=0xFFFFFFFE_00000001, res=0x00000001.
- DIVS a=0xFFFFFFF9 (-7), b=2 → prod=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3); same operands with MODS → res=0xFFFFFFFF.
- DIVU a=100, b=0 → done one cycle after the accepting edge; dbz=1, prod=0x00000064_FFFFFFFF, res=0xFFFFFFFF. The next DIVU 100/7 → dbz=0, prod=0x00000002_0000000E.
- DIVS 0x80000000 / 0xFFFFFFFF → prod=0x00000000_80000000, dbz=0.
- Start MULU 5*6, then pulse start with MULU 2*2 at cycle 10 → second request ignored; prod=30 after 33 cycles. Repeat, and drop rst_n at cycle 15 → busy, done and prod go to 0 immediately, and no done pulse follows.
